ex_stage: RTL and testbench

- Execute stage. Consumes the ID/EX pipeline register outputs: PC, two register operands, immediate, and the WB/M/EX control fields.
- Computes the ALU result, branch target and zero flag, and registers them together with the WB/M control into the EX/MEM boundary.
- Contains an iterative radix-2 multiplier. While it is busy, the block asserts stall so that the upstream registers hold their contents.

---
 rtl/ex_stage.sv | 192 +++++++++++++++++++
 tb/tb_ex_stage.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage: ALU, branch-target adder and an iterative radix-2 multiplier,
// registering the result and the WB/M control into the EX/MEM boundary.
//
// Upstream handshake: stall is the only flow-control signal. While stall is 1,
// IF/ID and ID/EX must hold their contents and present the same instruction
// again. When stall is 0 at a rising edge, the instruction on the inputs is
// consumed (or discarded, if it is a bubble or flushed). A MUL raises stall
// in its accept cycle and keeps it high for all but its final busy cycle.
// out_valid marks a cycle in which the EX/MEM outputs hold a real result.
module ex_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            flush,
  input  logic            alu_src,
  input  logic [3:0]      alu_ctrl,
  input  logic [1:0]      wb_in,
  input  logic [1:0]      m_in,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  output logic            stall,
  output logic            out_valid,
  output logic [1:0]      wb_out,
  output logic [1:0]      m_out,
  output logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] branch_target,
  output logic            zero
);

  localparam int CW = $clog2(XLEN) + 1;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q;
  logic [CW-1:0]     count_q;
  logic [XLEN-1:0]   mcand_q;
  logic [XLEN-1:0]   mplier_q;
  logic [XLEN-1:0]   acc_q;
  logic [1:0]        wb_lat_q;
  logic [1:0]        m_lat_q;
  logic [XLEN-1:0]   sd_lat_q;
  logic [XLEN-1:0]   bt_lat_q;

  logic              out_valid_q;
  logic [1:0]        wb_out_q;
  logic [1:0]        m_out_q;
  logic [XLEN-1:0]   alu_result_q;
  logic [XLEN-1:0]   store_data_q;
  logic [XLEN-1:0]   branch_target_q;
  logic              zero_q;

  logic [XLEN-1:0]   op_b;
  logic [XLEN-1:0]   alu_d;
  logic [XLEN-1:0]   acc_d;
  logic [XLEN-1:0]   bt_d;
  logic              is_mul;
  logic              last_busy;

  assign op_b      = alu_src ? imm : rs2_data;
  assign bt_d      = pc + (imm << 1);
  assign is_mul    = (alu_ctrl == OP_MUL);
  assign last_busy = (count_q == CW'(XLEN - 1));
  assign acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Single-cycle ALU result for every non-MUL operation.
  always_comb begin
    alu_d = '0;
    case (alu_ctrl)
      OP_AND:  alu_d = rs1_data & op_b;
      OP_OR:   alu_d = rs1_data | op_b;
      OP_ADD:  alu_d = rs1_data + op_b;
      OP_SUB:  alu_d = rs1_data - op_b;
      OP_SLT:  alu_d = {{(XLEN-1){1'b0}}, ($signed(rs1_data) < $signed(op_b))};
      default: alu_d = '0;
    endcase
  end

  // Hold upstream from the MUL accept cycle until the final busy cycle; reset
  // and flush both release it immediately.
  always_comb begin
    stall = 1'b0;
    if (!rst) begin
      if (state_q == IDLE)
        stall = in_valid && !flush && is_mul;
      else
        stall = !flush && !last_busy;
    end
  end

  // Control FSM, multiplier datapath and EX/MEM output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      count_q         <= '0;
      mcand_q         <= '0;
      mplier_q        <= '0;
      acc_q           <= '0;
      wb_lat_q        <= '0;
      m_lat_q         <= '0;
      sd_lat_q        <= '0;
      bt_lat_q        <= '0;
      out_valid_q     <= 1'b0;
      wb_out_q        <= '0;
      m_out_q         <= '0;
      alu_result_q    <= '0;
      store_data_q    <= '0;
      branch_target_q <= '0;
      zero_q          <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && !flush && is_mul) begin
            state_q     <= BUSY;
            count_q     <= '0;
            mcand_q     <= rs1_data;
            mplier_q    <= op_b;
            acc_q       <= '0;
            wb_lat_q    <= wb_in;
            m_lat_q     <= m_in;
            sd_lat_q    <= rs2_data;
            bt_lat_q    <= bt_d;
            out_valid_q <= 1'b0;
            wb_out_q    <= '0;
            m_out_q     <= '0;
          end else if (in_valid && !flush) begin
            out_valid_q     <= 1'b1;
            wb_out_q        <= wb_in;
            m_out_q         <= m_in;
            alu_result_q    <= alu_d;
            store_data_q    <= rs2_data;
            branch_target_q <= bt_d;
            zero_q          <= (alu_d == '0);
          end else begin
            // Bubble: control cleared, data registers keep their last values.
            out_valid_q <= 1'b0;
            wb_out_q    <= '0;
            m_out_q     <= '0;
          end
        end
        BUSY: begin
          if (flush) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            wb_out_q    <= '0;
            m_out_q     <= '0;
          end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            count_q  <= count_q + CW'(1);
            if (last_busy) begin
              state_q         <= IDLE;
              out_valid_q     <= 1'b1;
              wb_out_q        <= wb_lat_q;
              m_out_q         <= m_lat_q;
              alu_result_q    <= acc_d;
              store_data_q    <= sd_lat_q;
              branch_target_q <= bt_lat_q;
              zero_q          <= (acc_d == '0);
            end else begin
              out_valid_q <= 1'b0;
              wb_out_q    <= '0;
              m_out_q     <= '0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid     = out_valid_q;
  assign wb_out        = wb_out_q;
  assign m_out         = m_out_q;
  assign alu_result    = alu_result_q;
  assign store_data    = store_data_q;
  assign branch_target = branch_target_q;
  assign zero          = zero_q;

endmodule

// File: tb/tb_ex_stage.sv
// Testbench for ex_stage: directed scenarios plus randomized operations
// checked against an arithmetic reference model of the execute stage.
module tb_ex_stage;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            flush;
  logic            alu_src;
  logic [3:0]      alu_ctrl;
  logic [1:0]      wb_in;
  logic [1:0]      m_in;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] imm;
  logic            stall;
  logic            out_valid;
  logic [1:0]      wb_out;
  logic [1:0]      m_out;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] store_data;
  logic [XLEN-1:0] branch_target;
  logic            zero;

  int n_checks = 0;
  int n_fail   = 0;

  // Last values the EX/MEM data registers should be holding.
  logic [XLEN-1:0] exp_res;
  logic [XLEN-1:0] exp_sd;
  logic [XLEN-1:0] exp_bt;
  logic            exp_zero;

  ex_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush),
    .alu_src(alu_src), .alu_ctrl(alu_ctrl), .wb_in(wb_in), .m_in(m_in),
    .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .stall(stall), .out_valid(out_valid), .wb_out(wb_out), .m_out(m_out),
    .alu_result(alu_result), .store_data(store_data),
    .branch_target(branch_target), .zero(zero)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, failures=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  // Reference model: the result of one operation from its mathematical meaning.
  function automatic logic [XLEN-1:0] ref_alu(input logic [3:0] c,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    logic [2*XLEN-1:0] prod;
    prod = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 1 : 0;
      4'b1000: return prod[XLEN-1:0];
      default: return '0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [XLEN-1:0] act,
                     input logic [XLEN-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Present one single-cycle op, then check the EX/MEM outputs a cycle later.
  task automatic do_op(input string name, input logic [3:0] c, input logic src,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] r2,
                       input logic [XLEN-1:0] im, input logic [XLEN-1:0] p,
                       input logic [1:0] w, input logic [1:0] m);
    logic [XLEN-1:0] r;
    r = ref_alu(c, a, src ? im : r2);
    in_valid = 1'b1; flush = 1'b0; alu_ctrl = c; alu_src = src;
    rs1_data = a; rs2_data = r2; imm = im; pc = p; wb_in = w; m_in = m;
    #1;
    chk({name, " stall"}, XLEN'(stall), XLEN'(0));
    tick();
    chk({name, " out_valid"}, XLEN'(out_valid), XLEN'(1));
    chk({name, " alu_result"}, alu_result, r);
    chk({name, " zero"}, XLEN'(zero), XLEN'(r == 0));
    chk({name, " wb_out"}, XLEN'(wb_out), XLEN'(w));
    chk({name, " m_out"}, XLEN'(m_out), XLEN'(m));
    chk({name, " store_data"}, store_data, r2);
    chk({name, " branch_target"}, branch_target, p + (im << 1));
    exp_res = r; exp_sd = r2; exp_bt = p + (im << 1); exp_zero = (r == 0);
    in_valid = 1'b0;
  endtask

  // Start a MUL and check only the accept cycle.
  task automatic start_mul(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                           input logic [1:0] w, input logic [1:0] m);
    in_valid = 1'b1; flush = 1'b0; alu_ctrl = 4'b1000; alu_src = 1'b0;
    rs1_data = a; rs2_data = b; imm = rand64(); pc = rand64();
    wb_in = w; m_in = m;
    #1;
    chk("mul accept stall", XLEN'(stall), XLEN'(1));
  endtask

  // Scramble every input except flush/rst while the multiplier is busy.
  task automatic scramble();
    in_valid = 1'(($urandom() & 1));
    alu_ctrl = 4'($urandom_range(0, 15));
    alu_src  = 1'($urandom() & 1);
    rs1_data = rand64(); rs2_data = rand64(); imm = rand64(); pc = rand64();
    wb_in = 2'($urandom_range(0, 3)); m_in = 2'($urandom_range(0, 3));
  endtask

  // Full MUL with cycle-exact stall/out_valid checks and the final result.
  task automatic do_mul(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [1:0] w, input logic [1:0] m);
    logic [XLEN-1:0] r, sd, bt;
    int bad_valid, bad_stall;
    bad_valid = 0; bad_stall = 0;
    r = ref_alu(4'b1000, a, b);
    start_mul(a, b, w, m);
    sd = rs2_data; bt = pc + (imm << 1);
    for (int i = 1; i <= XLEN; i++) begin
      tick();
      if (out_valid !== 1'b0 || wb_out !== 2'b00 || m_out !== 2'b00) bad_valid++;
      if (i == 1) chk("mul hold alu_result", alu_result, exp_res);
      scramble();
      if (i == XLEN) in_valid = 1'b0;
      #1;
      if (stall !== (i < XLEN)) bad_stall++;
    end
    chk("mul busy out_valid errors", XLEN'(bad_valid), XLEN'(0));
    chk("mul busy stall errors", XLEN'(bad_stall), XLEN'(0));
    tick();
    chk("mul out_valid", XLEN'(out_valid), XLEN'(1));
    chk("mul alu_result", alu_result, r);
    chk("mul zero", XLEN'(zero), XLEN'(r == 0));
    chk("mul wb_out", XLEN'(wb_out), XLEN'(w));
    chk("mul m_out", XLEN'(m_out), XLEN'(m));
    chk("mul store_data", store_data, sd);
    chk("mul branch_target", branch_target, bt);
    exp_res = r; exp_sd = sd; exp_bt = bt; exp_zero = (r == 0);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; alu_ctrl = 4'b1000; alu_src = 1'b0;
    wb_in = 2'b11; m_in = 2'b11; pc = 64'h40; rs1_data = 3; rs2_data = 4; imm = 1;
    tick(); tick();
    chk("reset stall", XLEN'(stall), XLEN'(0));
    chk("reset out_valid", XLEN'(out_valid), XLEN'(0));
    chk("reset wb_out", XLEN'(wb_out), XLEN'(0));
    chk("reset m_out", XLEN'(m_out), XLEN'(0));
    chk("reset alu_result", alu_result, '0);
    chk("reset store_data", store_data, '0);
    chk("reset branch_target", branch_target, '0);
    chk("reset zero", XLEN'(zero), XLEN'(0));
    in_valid = 1'b0; rst = 1'b0;
    exp_res = '0; exp_sd = '0; exp_bt = '0; exp_zero = 1'b0;
    tick();
  endtask

  task automatic test_alu();
    do_op("add", 4'b0010, 1'b0, 64'd5, 64'd7, 64'd0, 64'd0, 2'b10, 2'b01);
    do_op("sub zero", 4'b0110, 1'b0, 64'h40, 64'h40, 64'd8, 64'h100, 2'b01, 2'b10);
    chk("sub branch_target 0x110", branch_target, 64'h110);
    do_op("sub wrap", 4'b0110, 1'b0, 64'd0, 64'd1, 64'd0, 64'd0, 2'b11, 2'b00);
    chk("sub wrap all ones", alu_result, 64'hFFFF_FFFF_FFFF_FFFF);
    do_op("slt -1<1", 4'b0111, 1'b0, '1, 64'd1, 64'd0, 64'd0, 2'b00, 2'b00);
    chk("slt -1<1 is 1", alu_result, 64'd1);
    do_op("slt 1<imm-1", 4'b0111, 1'b1, 64'd1, 64'd99, '1, 64'd4, 2'b01, 2'b01);
    chk("slt 1<-1 is 0", alu_result, 64'd0);
    do_op("unused 1111", 4'b1111, 1'b0, 64'd9, 64'd9, 64'd0, 64'd0, 2'b10, 2'b10);
    do_op("and", 4'b0000, 1'b1, 64'hF0F0, 64'd0, 64'hFF00, 64'd8, 2'b01, 2'b11);
    do_op("or", 4'b0001, 1'b0, 64'hF0F0, 64'h0F0F, 64'd3, 64'd8, 2'b11, 2'b01);
  endtask

  task automatic test_bubble();
    scramble(); in_valid = 1'b0; flush = 1'b0;
    tick();
    chk("bubble out_valid", XLEN'(out_valid), XLEN'(0));
    chk("bubble wb_out", XLEN'(wb_out), XLEN'(0));
    chk("bubble hold alu_result", alu_result, exp_res);
    chk("bubble hold store_data", store_data, exp_sd);
    alu_ctrl = 4'b0010; in_valid = 1'b1; flush = 1'b1; wb_in = 2'b11; m_in = 2'b11;
    tick();
    chk("flush idle out_valid", XLEN'(out_valid), XLEN'(0));
    chk("flush idle m_out", XLEN'(m_out), XLEN'(0));
    chk("flush idle hold branch_target", branch_target, exp_bt);
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic test_mul();
    do_mul(64'h1234, 64'h10, 2'b10, 2'b11);
    chk("mul 0x1234*0x10", alu_result, 64'h12340);
    do_mul(64'h8000_0000_0000_0000, 64'd2, 2'b01, 2'b01);
    chk("mul 2^63*2 zero", XLEN'(zero), XLEN'(1));
  endtask

  task automatic test_back_to_back();
    do_mul(64'd7, 64'd6, 2'b11, 2'b10);
    do_mul('1, '1, 2'b01, 2'b00);
    do_op("add after mul", 4'b0010, 1'b1, 64'd100, 64'd5, 64'd23, 64'h8, 2'b10, 2'b01);
  endtask

  task automatic test_flush_mul();
    start_mul(64'h1234, 64'h10, 2'b10, 2'b11);
    for (int i = 1; i <= 20; i++) begin
      tick();
      scramble();
    end
    flush = 1'b1; in_valid = 1'b1; alu_ctrl = 4'b0010;
    #1;
    chk("flush busy stall", XLEN'(stall), XLEN'(0));
    tick();
    chk("flush busy out_valid", XLEN'(out_valid), XLEN'(0));
    chk("flush busy wb_out", XLEN'(wb_out), XLEN'(0));
    chk("flush busy m_out", XLEN'(m_out), XLEN'(0));
    flush = 1'b0;
    do_op("add after flush", 4'b0010, 1'b0, 64'd5, 64'd7, 64'd2, 64'h20, 2'b10, 2'b01);
  endtask

  task automatic test_reset_mul();
    start_mul(64'h1234, 64'h10, 2'b10, 2'b11);
    for (int i = 1; i <= 30; i++) begin
      tick();
      scramble();
    end
    rst = 1'b1;
    #1;
    chk("rst busy stall", XLEN'(stall), XLEN'(0));
    tick();
    chk("rst busy out_valid", XLEN'(out_valid), XLEN'(0));
    chk("rst busy alu_result", alu_result, '0);
    chk("rst busy store_data", store_data, '0);
    chk("rst busy branch_target", branch_target, '0);
    chk("rst busy wb_out", XLEN'({wb_out, m_out}), XLEN'(0));
    rst = 1'b0; in_valid = 1'b0;
    exp_res = '0; exp_sd = '0; exp_bt = '0; exp_zero = 1'b0;
    do_mul(64'd3, 64'd4, 2'b01, 2'b10);
    chk("mul 3*4 after reset", alu_result, 64'd12);
  endtask

  task automatic test_random();
    logic [3:0] codes [8];
    logic [3:0] c;
    logic [XLEN-1:0] a, b;
    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1000, 4'b0011, 4'b1111};
    for (int n = 0; n < 40; n++) begin
      c = codes[$urandom_range(0, 7)];
      a = ($urandom_range(0, 3) == 0) ? XLEN'($urandom_range(0, 3)) : rand64();
      b = ($urandom_range(0, 3) == 0) ? a : rand64();
      if (c == 4'b1000 && n % 4 == 0)
        do_mul(a, b, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      else if (c != 4'b1000)
        do_op("random", c, 1'($urandom() & 1), a, b, rand64(), rand64(),
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) test_bubble();
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_bubble();
    test_mul();
    test_back_to_back();
    test_flush_mul();
    test_reset_mul();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
